// File: rtl/wheel_velocity.sv
// wheel_velocity: inverse mecanum kinematics in sign-magnitude fixed point.
// Wheel speeds w1..w4 come from (vx, vy, wz). K*wz and the four 1/r scalings use
// sequential shift-add multipliers, one multiplier bit per clock.

// Sequential sign-magnitude multiplier: |a|*|b| >> Q_WIDTH, saturating.
module wheel_velocity_mul #(
   parameter int N_WIDTH = 17,
   parameter int Q_WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               step,
   input  logic [N_WIDTH-1:0] a,
   input  logic [N_WIDTH-1:0] b,
   output logic [N_WIDTH-1:0] p,
   output logic               ovf
);
   localparam int M  = N_WIDTH - 1;
   localparam int PW = 2 * M;

   logic [PW-1:0] acc, mcand, shifted;
   logic [M-1:0]  mplier, mag;
   logic          sgn;

   // load captures the operand magnitudes; each step consumes one multiplier bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         sgn    <= 1'b0;
      end else if (load) begin
         acc    <= '0;
         mcand  <= PW'(a[M-1:0]);
         mplier <= b[M-1:0];
         sgn    <= a[M] ^ b[M];
      end else if (step) begin
         if (mplier[0]) acc <= acc + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end

   // rescale, saturate, and never emit negative zero
   always_comb begin
      shifted = acc >> Q_WIDTH;
      ovf     = |shifted[PW-1:M];
      mag     = ovf ? '1 : shifted[M-1:0];
      p       = {sgn & (|mag), mag};
   end
endmodule

module wheel_velocity #(
   parameter int                 N_WIDTH = 17,
   parameter int                 Q_WIDTH = 8,
   parameter logic [N_WIDTH-1:0] INV_R   = 17'h01B79,
   parameter logic [N_WIDTH-1:0] K_LXLY  = 17'h00033
) (
   input  logic               WHEEL_VELOCITY_CLOCK_50,
   input  logic               WHEEL_VELOCITY_Reset_InLow,
   input  logic               WHEEL_VELOCITY_Start_InHigh,
   input  logic [N_WIDTH-1:0] WHEEL_VELOCITY_VX_InBus,
   input  logic [N_WIDTH-1:0] WHEEL_VELOCITY_VY_InBus,
   input  logic [N_WIDTH-1:0] WHEEL_VELOCITY_WZ_InBus,
   output logic [N_WIDTH-1:0] WHEEL_VELOCITY_W1_OutBus,
   output logic [N_WIDTH-1:0] WHEEL_VELOCITY_W2_OutBus,
   output logic [N_WIDTH-1:0] WHEEL_VELOCITY_W3_OutBus,
   output logic [N_WIDTH-1:0] WHEEL_VELOCITY_W4_OutBus,
   output logic               WHEEL_VELOCITY_Busy_OutHigh,
   output logic               WHEEL_VELOCITY_Done_OutHigh,
   output logic               WHEEL_VELOCITY_Overflow_OutHigh
);
   localparam int M  = N_WIDTH - 1;
   localparam int CW = $clog2(M);

   typedef enum logic [2:0] {IDLE, MUL_K, SUM, MUL_R, DONE} state_t;

   logic clk, rst_n;
   assign clk   = WHEEL_VELOCITY_CLOCK_50;
   assign rst_n = WHEEL_VELOCITY_Reset_InLow;

   state_t                   state, state_nxt;
   logic [CW-1:0]            cnt;
   logic                     last;
   logic                     k_load, k_step, r_load, r_step;
   logic [N_WIDTH-1:0]       vx_r, vy_r, kw;
   logic                     k_ovf, ovf_acc, add_ovf;
   logic [N_WIDTH:0]         vpv, vmv, a1, a2, a3, a4;
   logic [3:0][N_WIDTH-1:0]  s, wp;
   logic [3:0]               r_ovf;

   // Sign-magnitude add returning {overflow, sign, magnitude}; zero is always +0.
   function automatic logic [N_WIDTH:0] sm_add(input logic [N_WIDTH-1:0] a,
                                                input logic [N_WIDTH-1:0] b);
      logic [M:0]   sum;
      logic [M-1:0] mag;
      logic         sgn, ov;
      ov  = 1'b0;
      sum = '0;
      if (a[M] == b[M]) begin
         sum = {1'b0, a[M-1:0]} + {1'b0, b[M-1:0]};
         ov  = sum[M];
         mag = ov ? '1 : sum[M-1:0];
         sgn = a[M];
      end else if (a[M-1:0] >= b[M-1:0]) begin
         mag = a[M-1:0] - b[M-1:0];
         sgn = a[M];
      end else begin
         mag = b[M-1:0] - a[M-1:0];
         sgn = b[M];
      end
      if (mag == '0) sgn = 1'b0;
      return {ov, sgn, mag};
   endfunction

   function automatic logic [N_WIDTH-1:0] sm_neg(input logic [N_WIDTH-1:0] x);
      return {~x[M], x[M-1:0]};
   endfunction

   function automatic logic [N_WIDTH-1:0] sm_norm(input logic [N_WIDTH-1:0] x);
      return {x[M] & (|x[M-1:0]), x[M-1:0]};
   endfunction

   assign last = (cnt == CW'(M - 1));

   // state register and bit counter shared by both multiply phases
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= ((state == MUL_K || state == MUL_R) && !last) ? cnt + 1'b1 : '0;
      end
   end

   // next-state and multiplier control strobes
   always_comb begin
      state_nxt = state;
      k_load    = 1'b0;
      k_step    = 1'b0;
      r_load    = 1'b0;
      r_step    = 1'b0;
      case (state)
         IDLE:  if (WHEEL_VELOCITY_Start_InHigh) begin
                   k_load    = 1'b1;
                   state_nxt = MUL_K;
                end
         MUL_K: begin
                   k_step = 1'b1;
                   if (last) state_nxt = SUM;
                end
         SUM:   begin
                   r_load    = 1'b1;
                   state_nxt = MUL_R;
                end
         MUL_R: begin
                   r_step = 1'b1;
                   if (last) state_nxt = DONE;
                end
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   wheel_velocity_mul #(.N_WIDTH(N_WIDTH), .Q_WIDTH(Q_WIDTH)) u_mul_k (
      .clk(clk), .rst_n(rst_n), .load(k_load), .step(k_step),
      .a(sm_norm(WHEEL_VELOCITY_WZ_InBus)), .b(K_LXLY), .p(kw), .ovf(k_ovf)
   );

   // pre-scale sums, evaluated left to right as (vx +/- vy) +/- K*wz
   always_comb begin
      vpv     = sm_add(vx_r, vy_r);
      vmv     = sm_add(vx_r, sm_neg(vy_r));
      a1      = sm_add(vpv[M:0] == '0 ? vmv[M:0] : vmv[M:0], sm_neg(kw));
      a2      = sm_add(vpv[M:0], kw);
      a3      = sm_add(vpv[M:0], sm_neg(kw));
      a4      = sm_add(vmv[M:0], kw);
      s       = {a4[M:0], a3[M:0], a2[M:0], a1[M:0]};
      add_ovf = vpv[N_WIDTH] | vmv[N_WIDTH] | a1[N_WIDTH] | a2[N_WIDTH] |
                a3[N_WIDTH] | a4[N_WIDTH];
   end

   for (genvar i = 0; i < 4; i++) begin : g_lane
      wheel_velocity_mul #(.N_WIDTH(N_WIDTH), .Q_WIDTH(Q_WIDTH)) u_mul_r (
         .clk(clk), .rst_n(rst_n), .load(r_load), .step(r_step),
         .a(s[i]), .b(INV_R), .p(wp[i]), .ovf(r_ovf[i])
      );
   end

   // operand latch, saturation accumulation and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vx_r                            <= '0;
         vy_r                            <= '0;
         ovf_acc                         <= 1'b0;
         WHEEL_VELOCITY_W1_OutBus        <= '0;
         WHEEL_VELOCITY_W2_OutBus        <= '0;
         WHEEL_VELOCITY_W3_OutBus        <= '0;
         WHEEL_VELOCITY_W4_OutBus        <= '0;
         WHEEL_VELOCITY_Busy_OutHigh     <= 1'b0;
         WHEEL_VELOCITY_Done_OutHigh     <= 1'b0;
         WHEEL_VELOCITY_Overflow_OutHigh <= 1'b0;
      end else begin
         WHEEL_VELOCITY_Done_OutHigh <= 1'b0;
         if (k_load) begin
            vx_r                        <= sm_norm(WHEEL_VELOCITY_VX_InBus);
            vy_r                        <= sm_norm(WHEEL_VELOCITY_VY_InBus);
            ovf_acc                     <= 1'b0;
            WHEEL_VELOCITY_Busy_OutHigh <= 1'b1;
         end
         if (r_load) ovf_acc <= ovf_acc | k_ovf | add_ovf;
         if (state == DONE) begin
            WHEEL_VELOCITY_W1_OutBus        <= wp[0];
            WHEEL_VELOCITY_W2_OutBus        <= wp[1];
            WHEEL_VELOCITY_W3_OutBus        <= wp[2];
            WHEEL_VELOCITY_W4_OutBus        <= wp[3];
            WHEEL_VELOCITY_Overflow_OutHigh <= ovf_acc | (|r_ovf);
            WHEEL_VELOCITY_Done_OutHigh     <= 1'b1;
            WHEEL_VELOCITY_Busy_OutHigh     <= 1'b0;
         end
      end
   end
endmodule
